// File: rtl/crc_pkg.sv
// Shared CRC definitions: verdict cause encodings, receiver FSM states and the
// default CRC-16 constants used by the receive checker and future transmitter.
package crc_pkg;

    typedef enum logic [1:0] {
        CAUSE_OK      = 2'd0,
        CAUSE_CRC     = 2'd1,
        CAUSE_RUNT    = 2'd2,
        CAUSE_PARTIAL = 2'd3
    } crc_cause_t;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } crc_state_t;

    localparam logic [15:0] CRC16_POLY    = 16'h8005;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h0000;

endpackage

// File: rtl/crc_rec_param_if.sv
// Bit-serial frame port of the CRC receive checker plus its verdict and debug outputs.
interface crc_rec_param_if
    import crc_pkg::*;
#(
    parameter int CRC_W = 16,
    parameter int CNT_W = 8
) ();

    // Framing: enable stays high for every bit-time of a frame and data_in is
    // sampled on each such edge; the first edge with enable low closes the frame
    // and crc_valid pulses for one cycle afterwards (no backpressure exists).
    logic             enable;
    logic             data_in;
    logic             clr_count;
    logic             busy;
    logic             crc_valid;
    logic             crc_error;
    logic [1:0]       err_cause;
    logic [CRC_W-1:0] residue;
    logic [CNT_W-1:0] err_count;
    crc_state_t       dbg_state;

    modport master (
        output enable, data_in, clr_count,
        input  busy, crc_valid, crc_error, err_cause, residue, err_count, dbg_state
    );

    modport slave (
        input  enable, data_in, clr_count,
        output busy, crc_valid, crc_error, err_cause, residue, err_count, dbg_state
    );

endinterface

// File: rtl/crc_lfsr_step.sv
// Single-bit Galois CRC update, MSB-first; shared by the receive checker and transmitter.
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC16_POLY)
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc_out
);

    logic fb;

    always_comb begin
        fb      = crc_in[CRC_W-1] ^ bit_in;
        crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

endmodule

// File: rtl/crc_rec_param.sv
// Parametrised serial CRC receive checker: accumulates a CRC over an enable-framed
// bit stream, optionally skipping symbol framing bits, and issues a one-cycle verdict.
module crc_rec_param
    import crc_pkg::*;
#(
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC16_POLY),
    parameter logic [CRC_W-1:0] INIT    = '1,
    parameter logic [CRC_W-1:0] RESIDUE = '0,
    parameter bit               FRAMED  = 1'b1,
    parameter int               SYM_LEN = 10,
    parameter int               CNT_W   = 8
) (
    input logic            clk,
    input logic            reset,
    crc_rec_param_if.slave bus
);

    localparam int               SYM_W    = $clog2(SYM_LEN);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_LEN - 1);

    crc_state_t       state, state_nxt;
    logic [CRC_W-1:0] crc, crc_nxt, crc_step;
    logic [SYM_W-1:0] sym_cnt, sym_nxt;
    logic             data_seen, seen_nxt;
    logic             valid_q, valid_nxt;
    logic             error_q, error_nxt;
    crc_cause_t       cause_q, cause_nxt;
    logic [CRC_W-1:0] residue_q, residue_nxt;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic             take_bit;
    logic             is_data;

    crc_lfsr_step #(.CRC_W(CRC_W), .POLY(POLY)) u_step (
        .crc_in  (crc),
        .bit_in  (bus.data_in),
        .crc_out (crc_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            crc       <= INIT;
            sym_cnt   <= '0;
            data_seen <= 1'b0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            cause_q   <= CAUSE_OK;
            residue_q <= '0;
            count_q   <= '0;
        end else begin
            state     <= state_nxt;
            crc       <= crc_nxt;
            sym_cnt   <= sym_nxt;
            data_seen <= seen_nxt;
            valid_q   <= valid_nxt;
            error_q   <= error_nxt;
            cause_q   <= cause_nxt;
            residue_q <= residue_nxt;
            count_q   <= count_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        crc_nxt     = crc;
        sym_nxt     = sym_cnt;
        seen_nxt    = data_seen;
        valid_nxt   = 1'b0;
        cause_nxt   = CAUSE_OK;
        residue_nxt = residue_q;
        count_nxt   = count_q;
        take_bit    = 1'b0;
        is_data     = !FRAMED || (sym_cnt != '0 && sym_cnt != SYM_LAST);

        case (state)
            IDLE: begin
                if (bus.enable) begin
                    state_nxt = RECV;
                    take_bit  = 1'b1;
                end
            end
            RECV: begin
                if (bus.enable) begin
                    take_bit = 1'b1;
                end else begin
                    state_nxt   = IDLE;
                    valid_nxt   = 1'b1;
                    residue_nxt = crc;
                    crc_nxt     = INIT;
                    sym_nxt     = '0;
                    seen_nxt    = 1'b0;
                    // A frame with no data bits always ends mid-symbol when framed,
                    // so runt is tested first or it could never be reported.
                    if (!data_seen)                        cause_nxt = CAUSE_RUNT;
                    else if (FRAMED && sym_cnt != '0)      cause_nxt = CAUSE_PARTIAL;
                    else if (crc != RESIDUE)               cause_nxt = CAUSE_CRC;
                    else                                   cause_nxt = CAUSE_OK;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (take_bit) begin
            sym_nxt = (sym_cnt == SYM_LAST) ? '0 : sym_cnt + 1'b1;
            if (is_data) begin
                crc_nxt  = crc_step;
                seen_nxt = 1'b1;
            end
        end

        error_nxt = valid_nxt && (cause_nxt != CAUSE_OK);

        // The counter moves on the verdict edge, so a clear on that same edge keeps the new error.
        if (bus.clr_count)
            count_nxt = error_nxt ? CNT_W'(1) : '0;
        else if (error_nxt && count_q != '1)
            count_nxt = count_q + 1'b1;
    end

    assign bus.busy      = (state == RECV);
    assign bus.crc_valid = valid_q;
    assign bus.crc_error = error_q;
    assign bus.err_cause = cause_q;
    assign bus.residue   = residue_q;
    assign bus.err_count = count_q;
    assign bus.dbg_state = state;

endmodule
